// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Two-master to one-slave Wishbone classic arbiter. Contention is resolved
// round-robin (the master that was not granted last wins), a grant is held
// for as long as the owning master keeps cyc high, and a watchdog aborts a
// strobe that the slave leaves unanswered so a dead peripheral cannot hang
// the CPU.
//
// Parameters
//   timeout_cycles  strobe cycles without ack before the access is aborted
//                   (2..65535); the abort happens on the timeout_cycles-th
//                   strobe cycle
//   err_data        read data handed back to the master on an aborted access
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   m0_* / m1_*                   Wishbone master-side ports (adr/dat/sel/we/
//                                 cyc/stb in, dat/ack out)
//   s_*                           Wishbone slave-side port
//   gnt_o                         one-hot current grant, 00 while idle
//   timeout_o                     one-cycle pulse the cycle after an abort
//   timeout_cnt_o                 saturating count of aborted accesses
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int unsigned timeout_cycles = 255,
  parameter logic [31:0] err_data       = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  // master 1
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  // slave
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  // status
  output logic [1:0]  gnt_o,
  output logic        timeout_o,
  output logic [7:0]  timeout_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  // Watchdog value on the last strobe cycle the slave is allowed to answer.
  localparam logic [15:0] WDOG_LAST = 16'(timeout_cycles - 1);

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;   // 0 = m0 granted last, 1 = m1
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        granted;
  logic        sel_m1;
  logic        mx_stb;
  logic        abort;

  // Strobe of whichever master owns the bus, and the abort decision. A slave
  // ack on the final cycle wins over the abort.
  always_comb begin
    granted = (state_q != IDLE);
    sel_m1  = (state_q == GRANT1);
    mx_stb  = sel_m1 ? m1_stb_i : m0_stb_i;
    abort   = granted && mx_stb && !s_ack_i && (wdog_q == WDOG_LAST);
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    last_gnt_d = last_gnt_q;

    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_gnt_q ? GRANT0 : GRANT1;
        end else if (m0_cyc_i) begin
          state_d = GRANT0;
        end else if (m1_cyc_i) begin
          state_d = GRANT1;
        end
      end
      // Leaving a grant always passes through IDLE, which gives the one-cycle
      // gap between owners and lets the other master win the next round.
      GRANT0: if (!m0_cyc_i) state_d = IDLE;
      GRANT1: if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && state_d == GRANT0) last_gnt_d = 1'b0;
    if (state_q == IDLE && state_d == GRANT1) last_gnt_d = 1'b1;

    // The watchdog only measures an uninterrupted, unanswered strobe.
    if (!granted || s_ack_i || !mx_stb || abort) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end

    tcnt_d = (abort && tcnt_q != 8'hFF) ? tcnt_q + 8'd1 : tcnt_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the simulator runs blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wdog_q     <= wdog_d;
      timeout_q  <= abort;
      tcnt_q     <= tcnt_d;
    end
  end

  // Data path: combinational routing from the owning master to the slave and
  // back. Outputs depend only on registered state and live inputs, so reset
  // forces them all to zero without waiting for a clock.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;

    if (granted) begin
      s_adr_o = sel_m1 ? m1_adr_i : m0_adr_i;
      s_dat_o = sel_m1 ? m1_dat_i : m0_dat_i;
      s_sel_o = sel_m1 ? m1_sel_i : m0_sel_i;
      s_we_o  = sel_m1 ? m1_we_i  : m0_we_i;
      s_cyc_o = sel_m1 ? m1_cyc_i : m0_cyc_i;
      // Withdrawing the strobe on abort tells the slave the access is gone.
      s_stb_o = mx_stb && !abort;
      if (sel_m1) begin
        m1_ack_o = s_ack_i || abort;
        m1_dat_o = abort ? err_data : s_dat_i;
      end else begin
        m0_ack_o = s_ack_i || abort;
        m0_dat_o = abort ? err_data : s_dat_i;
      end
    end
  end

  assign gnt_o         = {state_q == GRANT1, state_q == GRANT0};
  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//
// Directed bench for wb_rr_arbiter. Each test pushes the expected ack
// responses (master index and read data) into a scoreboard queue before it
// drives the masters; a monitor pops and compares on every master ack. A
// small slave model acks after a programmable number of strobe cycles and
// returns either a fixed word or the bitwise inverse of the address.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

  localparam int TO = 8;

  typedef struct {
    int          idx;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;
  logic [7:0]  timeout_cnt_o;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  // slave model controls
  int          slave_lat = 0;         // ack on this strobe cycle; 0 = never
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_dat = '0;
  logic [15:0] stb_cnt = '0;
  logic        sreq;

  // monitor state
  int         tout_pulses = 0;
  logic       gap_en = 1'b0;
  logic       seen_grant = 1'b0;
  logic [1:0] prev_gnt = 2'b00;
  int         idle_run = 0;
  logic       burst_watch = 1'b0;
  logic       saw_m0 = 1'b0;
  int         n;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.timeout_cycles(TO), .err_data(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
  );

  // Slave: keyed off the grant and the owning master's strobe so the ack does
  // not loop back through the arbiter's abort logic.
  assign sreq    = (gnt_o[0] && m0_stb_i) || (gnt_o[1] && m1_stb_i);
  assign s_ack_i = sreq && (slave_lat != 0) && (stb_cnt == 16'(slave_lat - 1));
  assign s_dat_i = use_fixed ? fixed_dat : ~s_adr_o;

  always @(posedge clk) stb_cnt <= (sreq && !s_ack_i) ? stb_cnt + 16'd1 : 16'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] dat);
    exp_t e;
    e.idx = idx;
    e.dat = dat;
    sb.push_back(e);
  endtask

  // Monitor: scoreboard compare on every ack, plus grant-gap and burst watch.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (rst && (m0_ack_o || m1_ack_o)) begin
      idx = m1_ack_o ? 1 : 0;
      check("ack_onehot", 64'(m0_ack_o && m1_ack_o), 64'd0);
      check("other_dat_zero", idx == 1 ? m0_dat_o : m1_dat_o, 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_ack: got ack on m%0d, expected none (t=%0t)", idx, $time);
      end else begin
        e = sb.pop_front();
        check("sb_master", 64'(idx), 64'(e.idx));
        check("sb_data", idx == 1 ? m1_dat_o : m0_dat_o, e.dat);
      end
    end
    if (timeout_o) tout_pulses++;
    if (burst_watch && s_cyc_o && s_adr_o == 32'h2000_0000) saw_m0 = 1'b1;
    if (gnt_o == 2'b00) begin
      idle_run++;
    end else begin
      if (gap_en && seen_grant && prev_gnt == 2'b00) check("idle_gap", 64'(idle_run), 64'd1);
      seen_grant = 1'b1;
      idle_run   = 0;
    end
    prev_gnt = gnt_o;
  end

  task automatic set_m(input int idx, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (idx == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
      m0_sel_i = cyc ? 4'hF : 4'h0;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
      m1_sel_i = cyc ? 4'hF : 4'h0;
    end
  endtask

  task automatic wait_ack(input int idx);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(idx == 0 ? m0_ack_o : m1_ack_o) && k < 200);
    if (!(idx == 0 ? m0_ack_o : m1_ack_o)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_wait_m%0d: no ack within 200 cycles, expected ack (t=%0t)", idx, $time);
    end
  endtask

  task automatic single(input int idx, input logic [31:0] adr, input logic we);
    @(posedge clk) #1 set_m(idx, 1'b1, 1'b1, we, adr, ~adr);
    wait_ack(idx);
    @(posedge clk) #1 set_m(idx, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic burst(input int idx, input logic [31:0] base, input int beats);
    @(posedge clk) #1 set_m(idx, 1'b1, 1'b1, 1'b0, base, '0);
    for (int k = 0; k < beats; k++) begin
      wait_ack(idx);
      @(posedge clk) #1;
      if (k < beats - 1) set_m(idx, 1'b1, 1'b1, 1'b0, base + 32'(4 * (k + 1)), '0);
      else               set_m(idx, 1'b0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Hard stop in case a wait escapes its bound.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    apply_reset();
    @(negedge clk);
    check("rst_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, gnt_o, m0_ack_o, m1_ack_o,
                      timeout_o, timeout_cnt_o}, 64'd0);
    check("rst_s_adr", s_adr_o, 64'd0);
    check("rst_m_dat", {m0_dat_o, m1_dat_o}, 64'd0);

    // ---------------- test 1: m0 single read, ack after 3 cycles ----------------
    slave_lat = 3; use_fixed = 1'b1; fixed_dat = 32'h0000_00A5;
    push_exp(0, 32'h0000_00A5);
    @(posedge clk) #1 set_m(0, 1'b1, 1'b1, 1'b0, 32'h7000_0004, '0);
    @(negedge clk) check("t1_gnt_before", gnt_o, 64'd0);
    @(negedge clk) check("t1_gnt_after", gnt_o, 64'd1);
    check("t1_s_adr", s_adr_o, 64'h7000_0004);
    wait_ack(0);
    check("t1_m1_ack", m1_ack_o, 64'd0);
    @(posedge clk) #1 set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk) check("t1_gnt_idle", gnt_o, 64'd0);
    use_fixed = 1'b0;

    // ---------------- test 2: alternating contention ----------------
    apply_reset();
    slave_lat = 2;
    push_exp(0, 32'hEFFF_FFFF); push_exp(1, 32'hEEFF_FFFF);
    push_exp(0, 32'hEFFF_FFFB); push_exp(1, 32'hEEFF_FFFB);
    push_exp(0, 32'hEFFF_FFF7); push_exp(1, 32'hEEFF_FFF7);
    push_exp(0, 32'hEFFF_FFF3); push_exp(1, 32'hEEFF_FFF3);
    seen_grant = 1'b0; gap_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++) single(0, 32'h1000_0000 + 32'(4 * k), 1'b0);
      end
      begin
        for (int k = 0; k < 4; k++) single(1, 32'h1100_0000 + 32'(4 * k), 1'b1);
      end
    join
    repeat (2) @(negedge clk);
    gap_en = 1'b0;

    // ---------------- test 3: m1 burst holds off m0 ----------------
    apply_reset();
    slave_lat = 2; saw_m0 = 1'b0;
    push_exp(1, 32'hDEFF_FFFF); push_exp(1, 32'hDEFF_FFFB); push_exp(1, 32'hDEFF_FFF7);
    push_exp(0, 32'hDFFF_FFFF);
    seen_grant = 1'b0; gap_en = 1'b1;
    fork
      begin
        burst_watch = 1'b1;
        burst(1, 32'h2100_0000, 3);
        burst_watch = 1'b0;
      end
      begin
        @(posedge clk);
        single(0, 32'h2000_0000, 1'b0);
      end
    join
    repeat (2) @(negedge clk);
    gap_en = 1'b0;
    check("t3_no_m0_in_burst", saw_m0, 64'd0);

    // ---------------- test 4: timeout abort and saturation ----------------
    apply_reset();
    slave_lat = 0; tout_pulses = 0;
    push_exp(0, 32'hFFFF_FFFF);
    @(posedge clk) #1 set_m(0, 1'b1, 1'b1, 1'b0, 32'h4000_0000, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m0_ack_o && n < 50);
    check("t4_abort_cycle", 64'(n), 64'd9);
    check("t4_s_stb_abort", s_stb_o, 64'd0);
    check("t4_pulse_pre", timeout_o, 64'd0);
    @(posedge clk) #1 set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk) check("t4_pulse", timeout_o, 64'd1);
    @(negedge clk) check("t4_pulse_post", timeout_o, 64'd0);
    check("t4_cnt1", timeout_cnt_o, 64'd1);
    check("t4_pulses1", 64'(tout_pulses), 64'd1);
    for (int k = 1; k < 300; k++) begin
      push_exp(0, 32'hFFFF_FFFF);
      single(0, 32'h4000_0000, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("t4_cnt_sat", timeout_cnt_o, 64'd255);
    check("t4_pulses300", 64'(tout_pulses), 64'd300);

    // ---------------- test 5: ack on the abort cycle wins ----------------
    apply_reset();
    slave_lat = TO; tout_pulses = 0;
    push_exp(0, 32'hAFFF_FFF7);
    single(0, 32'h5000_0008, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_no_pulse", 64'(tout_pulses), 64'd0);
    check("t5_cnt", timeout_cnt_o, 64'd0);

    // ---------------- test 6: async reset mid-write ----------------
    apply_reset();
    slave_lat = 0;
    @(posedge clk) #1 set_m(1, 1'b1, 1'b1, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk) check("t6_gnt1", gnt_o, 64'd2);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, gnt_o, m0_ack_o, m1_ack_o,
                         timeout_o}, 64'd0);
    check("t6_rst_s_adr", s_adr_o, 64'd0);
    check("t6_rst_s_dat", s_dat_o, 64'd0);
    check("t6_rst_m1_dat", m1_dat_o, 64'd0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk) #1 rst = 1'b1;
    slave_lat = 2;
    push_exp(0, 32'h9FFF_FFFF); push_exp(1, 32'h9EFF_FFFF);
    fork
      single(0, 32'h6000_0000, 1'b0);
      single(1, 32'h6100_0000, 1'b0);
    join
    repeat (3) @(negedge clk);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Two-master to one-slave Wishbone classic arbiter with round-robin fairness and a bus-hang watchdog. Used to share a single peripheral port, such as the i2c or lighting-control slave, between the LM32 data master and a second requester (DMA or a debug bridge). Placed between the requesters and one conbus slave port. A stalled slave cannot lock up the CPU.

Parameters:
timeout_cycles, 255, cycles a granted strobe may wait for slave ack before the arbiter aborts the access (range 2..65535)
err_data, 32'hFFFFFFFF, read data returned to the master on an aborted access

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
m0_adr_i / m1_adr_i  in  32  master address
m0_dat_i / m1_dat_i  in  32  master write data
m0_dat_o / m1_dat_o  out  32  read data to master
m0_sel_i / m1_sel_i  in  4  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_cyc_i / m1_cyc_i  in  1  bus cycle request
m0_stb_i / m1_stb_i  in  1  strobe
m0_ack_o / m1_ack_o  out  1  acknowledge
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_sel_o  out  4  slave byte selects
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_ack_i  in  1  slave acknowledge
gnt_o  out  2  one-hot current grant; 00 = idle
timeout_o  out  1  one-cycle pulse when an access is aborted
timeout_cnt_o  out  8  saturating count of aborted accesses

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, last_gnt = m1, watchdog = 0, timeout_cnt_o = 0, timeout_o = 0.
  - All s_* outputs 0, m*_ack_o = 0, m*_dat_o = 0, gnt_o = 00.
- A reset asserted mid-transaction aborts immediately. No ack is issued.
- States: IDLE, GRANT0, GRANT1.
- Transitions out of IDLE, registered, so grant latency is 1 cycle from cyc:
  - only m0_cyc_i high -> GRANT0.
  - only m1_cyc_i high -> GRANT1.
  - both high -> grant the master that is not last_gnt; the first contention after reset therefore goes to m0.
  - neither high -> stay in IDLE.
- Entering GRANTx sets last_gnt = x.
- In GRANTx:
  - s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o are combinational copies of master x's inputs.
  - mx_ack_o = s_ack_i and mx_dat_o = s_dat_i, both combinational.
  - The non-granted master sees ack 0 and dat 0.
- Grant is held as long as mx_cyc_i stays high. Multiple strobes under one cyc (block or RMW) are never interleaved.
- GRANTx -> IDLE on the first clock where mx_cyc_i is low. This holds even if it drops in the same cycle as ack. One idle cycle always separates grants.
- In IDLE, s_cyc_o = s_stb_o = 0.
- Watchdog (16-bit):
  - Cleared in IDLE, and on any cycle where s_ack_i = 1 or mx_stb_i = 0.
  - Otherwise increments while in GRANTx.
  - When watchdog == timeout_cycles-1 with no ack, abort the access in that cycle:
    - s_stb_o forced to 0.
    - mx_ack_o = 1 and mx_dat_o = err_data.
    - timeout_o = 1 (registered, asserts the following cycle for exactly 1 cycle).
    - timeout_cnt_o increments, saturating at 255.
    - watchdog returns to 0.
- Grant is kept after an abort; the master decides whether to drop cyc.
- A slave ack arriving on the abort cycle takes precedence: normal ack, no abort, no count.
- A master dropping cyc while in GRANTx without having received ack is legal. The slave simply sees cyc/stb fall.

Test Plan:
- Reset then m0 single read (addr 0x70000004), slave acks after 3 cycles with 0x000000A5 -> gnt_o 01 one cycle after cyc; m0_dat_o = 0x000000A5 with m0_ack_o; m1_ack_o stays 0; gnt_o 00 after cyc drops.
- Both cyc raised on the same cycle, each doing 4 back-to-back single transfers with cyc dropped between them -> grants alternate m0, m1, m0, m1 ... with exactly one IDLE cycle between grants; no master is starved.
- m1 holds cyc across 3 strobes while m0 requests continuously -> all 3 m1 transfers complete before m0 is granted; slave never sees m0's address during the m1 burst.
- Slave never acks, timeout_cycles = 8 -> m0_ack_o asserts on the 8th stb cycle with m0_dat_o = 0xFFFFFFFF; timeout_o pulses once; timeout_cnt_o = 1. Repeat 300 times -> timeout_cnt_o saturates at 255.
- Slave acks exactly on the abort cycle -> slave data returned; timeout_o stays 0; count unchanged.
- rst pulled low mid-write while in GRANT1 -> all outputs 0 asynchronously; after release, a fresh simultaneous request grants m0 first.
